// File: rtl/sdr_port_arbiter.sv
// Two-port arbiter in front of the single SDRAM controller port.
// Video scanout has fixed priority; a starvation counter forces a CPU grant
// after STARVE_MAX consecutive video wins over a pending CPU request.
// The granted request is captured and forwarded. Beat data is routed to the
// owner and beats are counted against the controller's done signal.
module sdr_port_arbiter #(
  parameter int ADDR_W     = 24,
  parameter int DATA_W     = 16,
  parameter int BURST_W    = 4,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk_sdr,
  input  logic              reset_n,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  input  logic [BURST_W-1:0] vid_len,
  output logic              vid_ack,
  output logic [DATA_W-1:0] vid_rdata,
  output logic              vid_rvalid,
  output logic              vid_done,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [BURST_W-1:0] cpu_len,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_wnext,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  output logic              cpu_done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [BURST_W-1:0] mem_len,
  input  logic              mem_ack,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_wnext,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  input  logic              mem_done,
  output logic              err
);

  // Beat counter needs one extra bit: len=0 means 2^BURST_W beats.
  localparam int CNT_W    = BURST_W + 1;
  localparam int STARVE_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0]    FULL_BEATS = {1'b1, {BURST_W{1'b0}}};
  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE_V = 3'd1,
    ISSUE_C = 3'd2,
    BUSY_V  = 3'd3,
    BUSY_C  = 3'd4
  } state_t;

  state_t               state_reg, state_next;
  logic [STARVE_W-1:0]  starve_reg, starve_next;
  logic [CNT_W-1:0]     beat_cnt_reg, beat_cnt_next;
  logic [CNT_W-1:0]     cnt_after;
  logic                 mem_req_reg, mem_req_next;
  logic                 mem_we_reg, mem_we_next;
  logic [ADDR_W-1:0]    mem_addr_reg, mem_addr_next;
  logic [BURST_W-1:0]   mem_len_reg, mem_len_next;
  logic                 vid_ack_reg, vid_ack_next;
  logic                 cpu_ack_reg, cpu_ack_next;
  logic                 vid_done_reg, vid_done_next;
  logic                 cpu_done_reg, cpu_done_next;
  logic                 err_reg, err_next;

  logic idle, busy_v, busy_c, busy;
  logic rd_ok, wr_ok, beat;
  logic grant_c, grant_v;
  logic [CNT_W-1:0] load_beats;

  assign idle   = (state_reg == IDLE);
  assign busy_v = (state_reg == BUSY_V);
  assign busy_c = (state_reg == BUSY_C);
  assign busy   = busy_v | busy_c;

  // Which beat kind is legal for the burst currently owning the port.
  assign rd_ok = busy_v | (busy_c & ~mem_we_reg);
  assign wr_ok = busy_c & mem_we_reg;
  assign beat  = (mem_rvalid & rd_ok) | (mem_wnext & wr_ok);

  // CPU wins when starved or when video is not asking; otherwise video wins.
  assign grant_c = idle & cpu_req & ((starve_reg == STARVE_LIM) | ~vid_req);
  assign grant_v = idle & vid_req & ~grant_c;

  assign load_beats = (mem_len_reg == '0) ? FULL_BEATS : {1'b0, mem_len_reg};

  // Zero-latency data routing; everything is quiet outside a data phase.
  assign vid_rdata  = busy ? mem_rdata : '0;
  assign cpu_rdata  = busy ? mem_rdata : '0;
  assign vid_rvalid = busy_v & mem_rvalid;
  assign cpu_rvalid = busy_c & ~mem_we_reg & mem_rvalid;
  assign cpu_wnext  = wr_ok & mem_wnext;
  assign mem_wdata  = wr_ok ? cpu_wdata : '0;

  assign vid_ack  = vid_ack_reg;
  assign cpu_ack  = cpu_ack_reg;
  assign vid_done = vid_done_reg;
  assign cpu_done = cpu_done_reg;
  assign mem_req  = mem_req_reg;
  assign mem_we   = mem_we_reg;
  assign mem_addr = mem_addr_reg;
  assign mem_len  = mem_len_reg;
  assign err      = err_reg;

  // Next-state, capture, beat accounting and protocol checking.
  always_comb begin
    state_next    = state_reg;
    starve_next   = starve_reg;
    beat_cnt_next = beat_cnt_reg;
    cnt_after     = beat_cnt_reg;
    mem_req_next  = mem_req_reg;
    mem_we_next   = mem_we_reg;
    mem_addr_next = mem_addr_reg;
    mem_len_next  = mem_len_reg;
    vid_ack_next  = 1'b0;
    cpu_ack_next  = 1'b0;
    vid_done_next = 1'b0;
    cpu_done_next = 1'b0;
    err_next      = err_reg;

    case (state_reg)
      IDLE: begin
        if (mem_rvalid || mem_wnext || mem_done || mem_ack) err_next = 1'b1;
        if (grant_c) begin
          mem_req_next  = 1'b1;
          mem_we_next   = cpu_we;
          mem_addr_next = cpu_addr;
          mem_len_next  = cpu_len;
          cpu_ack_next  = 1'b1;
          starve_next   = '0;
          state_next    = ISSUE_C;
        end else if (grant_v) begin
          mem_req_next  = 1'b1;
          mem_we_next   = 1'b0;
          mem_addr_next = vid_addr;
          mem_len_next  = vid_len;
          vid_ack_next  = 1'b1;
          if (cpu_req && starve_reg != STARVE_LIM) starve_next = starve_reg + 1'b1;
          state_next    = ISSUE_V;
        end
      end

      ISSUE_V, ISSUE_C: begin
        if (mem_rvalid || mem_wnext || mem_done) err_next = 1'b1;
        if (mem_ack) begin
          mem_req_next  = 1'b0;
          beat_cnt_next = load_beats;
          state_next    = (state_reg == ISSUE_V) ? BUSY_V : BUSY_C;
        end
      end

      BUSY_V, BUSY_C: begin
        if (mem_ack) err_next = 1'b1;
        if (mem_rvalid && !rd_ok) err_next = 1'b1;
        if (mem_wnext && !wr_ok) err_next = 1'b1;
        // A beat with nothing left to count is an overrun; hold at zero.
        if (beat) begin
          if (beat_cnt_reg == '0) err_next = 1'b1;
          else cnt_after = beat_cnt_reg - 1'b1;
        end
        beat_cnt_next = cnt_after;
        // Done is judged after the same-cycle beat has been counted.
        if (mem_done) begin
          if (cnt_after != '0) err_next = 1'b1;
          beat_cnt_next = '0;
          vid_done_next = busy_v;
          cpu_done_next = busy_c;
          state_next    = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_sdr) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      starve_reg   <= '0;
      beat_cnt_reg <= '0;
      mem_req_reg  <= 1'b0;
      mem_we_reg   <= 1'b0;
      mem_addr_reg <= '0;
      mem_len_reg  <= '0;
      vid_ack_reg  <= 1'b0;
      cpu_ack_reg  <= 1'b0;
      vid_done_reg <= 1'b0;
      cpu_done_reg <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      starve_reg   <= starve_next;
      beat_cnt_reg <= beat_cnt_next;
      mem_req_reg  <= mem_req_next;
      mem_we_reg   <= mem_we_next;
      mem_addr_reg <= mem_addr_next;
      mem_len_reg  <= mem_len_next;
      vid_ack_reg  <= vid_ack_next;
      cpu_ack_reg  <= cpu_ack_next;
      vid_done_reg <= vid_done_next;
      cpu_done_reg <= cpu_done_next;
      err_reg      <= err_next;
    end
  end

endmodule

// File: doc/sdr_port_arbiter.md
Name: sdr_port_arbiter

Overview:
- Two-port arbiter in front of the single 16-bit SDRAM controller port, clocked in the SDRAM domain.
- Shares the port between the video scanout fetcher (read-only bursts, latency-critical) and the CPU/DMA path (read/write bursts).
- Video has fixed priority; a starvation counter guarantees CPU progress.
- It captures the granted request, forwards it, routes beat data to the owner, and checks beat counts against the controller's done signal.

Parameters:
ADDR_W, 24, word address width
DATA_W, 16, data width
BURST_W, 4, burst length field width; len=0 encodes 2^BURST_W beats
STARVE_MAX, 4, consecutive video grants won over a pending CPU request before the CPU is forced

Ports:
clk_sdr  in  1  SDRAM-domain clock
reset_n  in  1  synchronous active-low reset
vid_req  in  1  video request, held until vid_ack
vid_addr  in  ADDR_W  video burst address
vid_len  in  BURST_W  video burst beats
vid_ack  out  1  one-cycle grant/capture pulse
vid_rdata  out  DATA_W  read beat data
vid_rvalid  out  1  read beat strobe
vid_done  out  1  one-cycle burst-complete pulse
cpu_req  in  1  CPU request, held until cpu_ack
cpu_we  in  1  1=write burst
cpu_addr  in  ADDR_W  CPU burst address
cpu_len  in  BURST_W  CPU burst beats
cpu_wdata  in  DATA_W  current write word
cpu_wnext  out  1  write word consumed; present next
cpu_ack  out  1  grant/capture pulse
cpu_rdata  out  DATA_W  read beat data
cpu_rvalid  out  1  read beat strobe
cpu_done  out  1  burst-complete pulse
mem_req  out  1  request to controller, held until mem_ack
mem_we  out  1  captured write flag
mem_addr  out  ADDR_W  captured address
mem_len  out  BURST_W  captured length
mem_ack  in  1  controller accepted request
mem_wdata  out  DATA_W  write data to controller
mem_wnext  in  1  controller consumed a write word
mem_rdata  in  DATA_W  read data from controller
mem_rvalid  in  1  read beat strobe
mem_done  in  1  burst finished
err  out  1  sticky protocol-error flag

Behaviour:
- Reset: state IDLE. All outputs 0, including err, the starve counter and the beat counter. Reset mid-burst abandons the burst with no done pulse; the controller shares the same reset.
- FSM states: IDLE, ISSUE_V, ISSUE_C, BUSY_V, BUSY_C.
- IDLE arbitration, evaluated at each edge:
  - cpu_req and starve==STARVE_MAX: grant CPU.
  - else vid_req: grant video.
  - else cpu_req: grant CPU.
  - Grant registers: req attributes into mem_*, vid_we forced to 0, an ack pulse for one cycle, mem_req=1, and the state moves to ISSUE_x.
- Starve counter:
  - Video granted while cpu_req=1: increment, saturating at STARVE_MAX.
  - Any CPU grant: clear.
- ISSUE_x:
  - mem_req held with stable attributes until mem_ack=1.
  - On mem_ack, next cycle: mem_req=0, state BUSY_x, beat counter loaded with the expected beats (len, or 2^BURST_W if len=0).
- BUSY_x data routing:
  - Combinational, zero latency. mem_rdata goes to both x_rdata; mem_rvalid goes to the owner's rvalid only.
  - CPU write: mem_wdata=cpu_wdata, cpu_wnext=mem_wnext. Otherwise mem_wdata=0 and cpu_wnext=0.
  - Each rvalid/wnext beat decrements the beat counter.
- BUSY_x completion:
  - On mem_done, next cycle: x_done=1 for one cycle, state IDLE.
  - If the counter was not 0 after accounting for any beat in the same cycle, set err.
  - A beat coinciding with mem_done is counted first.
- Back-to-back: earliest next grant is two cycles after mem_done. A new req raised during BUSY waits; its attributes must stay stable.
- Protocol violations set err, which stays set until reset; the event is otherwise ignored:
  - mem_rvalid, mem_wnext or mem_done in IDLE or ISSUE_x.
  - mem_rvalid during a CPU write or mem_wnext during a read.
  - A beat when the counter is 0; the counter stays 0, no wrap.
  - mem_ack outside ISSUE_x.
- Requests from both ports in the same cycle are resolved by the priority above; the loser's ack stays 0.

Test Plan:
- Single video read, addr 0x001234, len 4; controller acks after 2 cycles, gives 4 rvalid beats, then done.
  - vid_ack 1 cycle after req; mem_addr 0x001234, mem_we 0.
  - Exactly 4 vid_rvalid, 0 cpu_rvalid; vid_done 1 cycle after mem_done; err=0.
- CPU write, addr 0x00ABCD, len 0; controller pulses mem_wnext 16 times.
  - cpu_wnext mirrors all 16 pulses; mem_wdata tracks cpu_wdata.
  - cpu_done after mem_done; err=0.
- vid_req and cpu_req held continuously (STARVE_MAX=4).
  - Grant sequence V,V,V,V,C,V,V,V,V,C; starve clears on each C.
- Controller returns 3 beats for len 4, then mem_done.
  - Owner's done still pulses; err=1 and stays 1 through later clean bursts until reset_n=0.
- Stray mem_rvalid in IDLE, and mem_done in ISSUE_C before mem_ack.
  - No rvalid or done forwarded to either port; err=1.
- reset_n=0 for 1 cycle during BUSY_V after 2 of 8 beats.
  - All outputs 0 next cycle, state IDLE, no vid_done.
  - Pending cpu_req granted with cpu_ack 1 cycle after reset_n returns to 1.
